// File: rtl/stack_pkg.sv
// Shared defaults and operation decode for the LIFO stack unit.
package stack_pkg;

  localparam int unsigned N_DEFAULT          = 8;
  localparam int unsigned DEPTH_LOG2_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    SWAP = 2'b11
  } stack_op_e;

  // {push,pop} maps directly onto the enum encoding.
  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one falling-edge synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [N-1:0] mem [DEPTH];

  always_ff @(negedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack controller: count/pointer tracking, op decode, registered pop output and sticky error flags.
module stack_unit
  import stack_pkg::*;
#(
  parameter int unsigned N          = N_DEFAULT,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [N-1:0]          push_data,
  input  logic                  pop,
  output logic [N-1:0]          pop_data,
  output logic                  pop_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2-1:0] sp,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned AW    = DEPTH_LOG2;

  stack_op_e      op;
  logic [AW-1:0]  top_idx;
  logic [N-1:0]   top_data;
  logic           ram_we;
  logic [AW-1:0]  ram_waddr;

  logic [CW-1:0]  count_nxt;
  logic [N-1:0]   pop_data_nxt;
  logic           pop_valid_nxt;
  logic           overflow_nxt;
  logic           underflow_nxt;

  assign op      = decode_op(push, pop);
  assign sp      = count[AW-1:0];
  // sp-1 wraps to DEPTH-1 when full, which is exactly the top slot.
  assign top_idx = sp - AW'(1);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));

  stack_ram #(
    .N  (N),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (push_data),
    .raddr (top_idx),
    .rdata (top_data)
  );

  // Next-state and memory-write decode; clear overrides every operation.
  always_comb begin
    count_nxt     = count;
    pop_data_nxt  = pop_data;
    pop_valid_nxt = 1'b0;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;
    ram_we        = 1'b0;
    ram_waddr     = sp;

    if (clear) begin
      count_nxt     = CW'(0);
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else begin
      unique case (op)
        PUSH: begin
          if (full) begin
            overflow_nxt = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = sp;
            count_nxt = count + CW'(1);
          end
        end
        POP: begin
          if (empty) begin
            underflow_nxt = 1'b1;
          end else begin
            pop_data_nxt  = top_data;
            pop_valid_nxt = 1'b1;
            count_nxt     = count - CW'(1);
          end
        end
        SWAP: begin
          pop_valid_nxt = 1'b1;
          if (empty) begin
            pop_data_nxt = push_data;
          end else begin
            pop_data_nxt = top_data;
            ram_we       = 1'b1;
            ram_waddr    = top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      pop_data  <= pop_data_nxt;
      pop_valid <= pop_valid_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: LIFO order, full/empty bounds, swap/bypass, clear and async reset.
module tb_stack_unit;

  logic       clk = 1'b1;
  logic       rst_n;
  logic       clear;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic [4:0] count;
  logic [3:0] sp;
  logic       full, empty, overflow, underflow;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stack_unit #(.N(8), .DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .count     (count),
    .sp        (sp),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // One falling-edge cycle; outputs are stable 2 time units after the edge.
  task automatic cyc(input logic pu, input logic po, input logic [7:0] d, input logic cl);
    push = pu; pop = po; push_data = d; clear = cl;
    @(negedge clk);
    #2;
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; push_data = 8'h00;
    repeat (2) @(negedge clk);
    #2;
    vectors++; if (count !== 5'd0) begin $display("FAIL reset_count got %0d want 0", count); miscompares++; end
    vectors++; if (pop_data !== 8'h00) begin $display("FAIL reset_pop_data got %h want 00", pop_data); miscompares++; end
    vectors++; if (pop_valid !== 1'b0) begin $display("FAIL reset_pop_valid got %b want 0", pop_valid); miscompares++; end
    vectors++; if ({overflow, underflow} !== 2'b00) begin $display("FAIL reset_flags got %b want 00", {overflow, underflow}); miscompares++; end
    vectors++; if (empty !== 1'b1) begin $display("FAIL reset_empty got %b want 1", empty); miscompares++; end
    rst_n = 1'b1;
  endtask

  task automatic test_lifo();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h33; exp_d[1] = 8'h22; exp_d[2] = 8'h11;
    cyc(1'b1, 1'b0, 8'h11, 1'b0);
    cyc(1'b1, 1'b0, 8'h22, 1'b0);
    cyc(1'b1, 1'b0, 8'h33, 1'b0);
    vectors++; if (count !== 5'd3) begin $display("FAIL lifo_count got %0d want 3", count); miscompares++; end
    vectors++; if (sp !== 4'd3) begin $display("FAIL lifo_sp got %0d want 3", sp); miscompares++; end
    vectors++; if (empty !== 1'b0) begin $display("FAIL lifo_empty got %b want 0", empty); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      vectors++; if (pop_data !== exp_d[i]) begin $display("FAIL lifo_pop%0d got %h want %h", i, pop_data, exp_d[i]); miscompares++; end
      vectors++; if (pop_valid !== 1'b1) begin $display("FAIL lifo_valid%0d got %b want 1", i, pop_valid); miscompares++; end
    end
    vectors++; if (empty !== 1'b1) begin $display("FAIL lifo_final_empty got %b want 1", empty); miscompares++; end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++; if (pop_valid !== 1'b0) begin $display("FAIL lifo_valid_drop got %b want 0", pop_valid); miscompares++; end
  endtask

  task automatic test_full();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    vectors++; if (full !== 1'b1) begin $display("FAIL full_flag got %b want 1", full); miscompares++; end
    vectors++; if (overflow !== 1'b0) begin $display("FAIL full_no_ovf got %b want 0", overflow); miscompares++; end
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    vectors++; if (count !== 5'd16) begin $display("FAIL full_count got %0d want 16", count); miscompares++; end
    vectors++; if (sp !== 4'd0) begin $display("FAIL full_sp got %0d want 0", sp); miscompares++; end
    vectors++; if (overflow !== 1'b1) begin $display("FAIL full_overflow got %b want 1", overflow); miscompares++; end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++; if (pop_data !== 8'h0F) begin $display("FAIL full_pop got %h want 0f", pop_data); miscompares++; end
    vectors++; if (count !== 5'd15) begin $display("FAIL full_pop_count got %0d want 15", count); miscompares++; end
    vectors++; if (overflow !== 1'b1) begin $display("FAIL full_ovf_sticky got %b want 1", overflow); miscompares++; end
  endtask

  task automatic test_underflow();
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    vectors++; if (overflow !== 1'b0) begin $display("FAIL clr_overflow got %b want 0", overflow); miscompares++; end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++; if (underflow !== 1'b1) begin $display("FAIL udf_flag got %b want 1", underflow); miscompares++; end
    vectors++; if (pop_valid !== 1'b0) begin $display("FAIL udf_valid got %b want 0", pop_valid); miscompares++; end
    vectors++; if (count !== 5'd0) begin $display("FAIL udf_count got %0d want 0", count); miscompares++; end
    vectors++; if (pop_data !== 8'h0F) begin $display("FAIL udf_pop_data_held got %h want 0f", pop_data); miscompares++; end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    vectors++; if (underflow !== 1'b1) begin $display("FAIL udf_sticky got %b want 1", underflow); miscompares++; end
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    vectors++; if (underflow !== 1'b0) begin $display("FAIL udf_clear got %b want 0", underflow); miscompares++; end
  endtask

  task automatic test_swap();
    cyc(1'b1, 1'b0, 8'h33, 1'b0);
    cyc(1'b1, 1'b0, 8'h44, 1'b0);
    cyc(1'b1, 1'b1, 8'h55, 1'b0);
    vectors++; if (pop_data !== 8'h44) begin $display("FAIL swap_pop got %h want 44", pop_data); miscompares++; end
    vectors++; if (pop_valid !== 1'b1) begin $display("FAIL swap_valid got %b want 1", pop_valid); miscompares++; end
    vectors++; if (count !== 5'd2) begin $display("FAIL swap_count got %0d want 2", count); miscompares++; end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++; if (pop_data !== 8'h55) begin $display("FAIL swap_next got %h want 55", pop_data); miscompares++; end
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++; if (pop_data !== 8'h33) begin $display("FAIL swap_bottom got %h want 33", pop_data); miscompares++; end
  endtask

  task automatic test_bypass();
    cyc(1'b1, 1'b1, 8'h66, 1'b0);
    vectors++; if (pop_data !== 8'h66) begin $display("FAIL byp_pop got %h want 66", pop_data); miscompares++; end
    vectors++; if (pop_valid !== 1'b1) begin $display("FAIL byp_valid got %b want 1", pop_valid); miscompares++; end
    vectors++; if (count !== 5'd0) begin $display("FAIL byp_count got %0d want 0", count); miscompares++; end
    vectors++; if (empty !== 1'b1) begin $display("FAIL byp_empty got %b want 1", empty); miscompares++; end
    vectors++; if (underflow !== 1'b0) begin $display("FAIL byp_no_udf got %b want 0", underflow); miscompares++; end
  endtask

  task automatic test_clear_priority();
    cyc(1'b1, 1'b0, 8'h77, 1'b0);
    cyc(1'b1, 1'b0, 8'h88, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h99, 1'b1);
    vectors++; if (count !== 5'd0) begin $display("FAIL clr_pri_count got %0d want 0", count); miscompares++; end
    vectors++; if (pop_valid !== 1'b0) begin $display("FAIL clr_pri_valid got %b want 0", pop_valid); miscompares++; end
    vectors++; if (pop_data !== 8'h88) begin $display("FAIL clr_pri_data_held got %h want 88", pop_data); miscompares++; end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++; if (count !== 5'd5) begin $display("FAIL arst_pre_count got %0d want 5", count); miscompares++; end
    vectors++; if (pop_valid !== 1'b1) begin $display("FAIL arst_pre_valid got %b want 1", pop_valid); miscompares++; end
    rst_n = 1'b0;
    #1;
    vectors++; if (count !== 5'd0) begin $display("FAIL arst_count got %0d want 0", count); miscompares++; end
    vectors++; if (pop_valid !== 1'b0) begin $display("FAIL arst_valid got %b want 0", pop_valid); miscompares++; end
    vectors++; if (pop_data !== 8'h00) begin $display("FAIL arst_pop_data got %h want 00", pop_data); miscompares++; end
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    vectors++; if (underflow !== 1'b1) begin $display("FAIL arst_udf got %b want 1", underflow); miscompares++; end
    vectors++; if (count !== 5'd0) begin $display("FAIL arst_post_count got %0d want 0", count); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_full();
    test_underflow();
    test_swap();
    test_bypass();
    test_clear_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter N, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, giving stack depth 2**DEPTH_LOG2 (16 entries).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its falling edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous empty-the-stack request.
REQ-006 SHALL have port push  input  1  write push_data onto top of stack this cycle.
REQ-007 SHALL have port push_data  input  N  word to push.
REQ-008 SHALL have port pop  input  1  remove top-of-stack word this cycle.
REQ-009 SHALL have port pop_data  output  N  registered popped word.
REQ-010 SHALL have port pop_valid  output  1  one-cycle strobe, pop_data updated by the last edge.
REQ-011 SHALL have port count  output  DEPTH_LOG2+1  number of stored words, 0..2**DEPTH_LOG2.
REQ-012 SHALL have port sp  output  DEPTH_LOG2  index of next free slot, equal to count modulo depth.
REQ-013 SHALL have ports full and empty  output  1 each  count==2**DEPTH_LOG2 and count==0, combinational from count.
REQ-014 SHALL have ports overflow and underflow  output  1 each  sticky error flags.

Function
REQ-015 Storage convention SHALL be: top of stack = mem[count-1]; push writes mem[count], pop reads mem[count-1].
REQ-016 Push only, not full: SHALL write push_data to mem[count] and increment count by 1 at the same edge.
REQ-017 Pop only, not empty: SHALL load pop_data with mem[count-1], decrement count by 1, and assert pop_valid for exactly one cycle.
REQ-018 Push and pop together, not empty (including full): SHALL load pop_data with the old top, overwrite mem[count-1] with push_data, count unchanged, pop_valid asserted.
REQ-019 Push and pop together, empty: SHALL bypass push_data to pop_data, assert pop_valid, count stays 0, no memory write.
REQ-020 Push only when full: SHALL not write memory or change count, and SHALL set overflow.
REQ-021 Pop only when empty: SHALL leave pop_data and count unchanged, keep pop_valid low, and set underflow.
REQ-022 count SHALL never wrap; 0 and 2**DEPTH_LOG2 are saturation bounds guarded by REQ-020/021.
REQ-023 clear SHALL take priority over push and pop: count->0, overflow/underflow->0, pop_valid->0, pop_data held, memory contents untouched.
REQ-024 overflow and underflow SHALL remain set until clear or reset.
REQ-025 pop_valid SHALL deassert on the cycle following any pop unless another valid pop occurs.

Reset
REQ-026 rst_n low SHALL immediately force count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard any in-flight push/pop; memory contents need not be reset.
REQ-028 First state update after rst_n rises SHALL occur on the next falling clk edge.

Structure
REQ-029 A shared package stack_pkg SHALL hold default N, default DEPTH_LOG2, and an operation enum (IDLE, PUSH, POP, SWAP) decoded from {push,pop}.
REQ-030 Storage SHALL be a sub-module stack_ram: 2**DEPTH_LOG2 x N, one synchronous write port, one asynchronous read port, no reset.
REQ-031 stack_unit SHALL contain only pointer/count logic, op decode, output registers and flags.

Verification
REQ-032 Reset then push 0x11,0x22,0x33 on three cycles -> count=3, sp=3, empty=0; then three pops -> pop_data 0x33,0x22,0x11 each with one-cycle pop_valid, final empty=1.
REQ-033 Push 16 words 0x00..0x0F, then push 0xAA -> full=1, count=16, sp=0, overflow=1, next pop returns 0x0F.
REQ-034 From empty, pop -> underflow=1, pop_valid=0, count=0; then clear -> underflow=0.
REQ-035 With 0x44 on top (count=2), push 0x55 with pop in same cycle -> pop_data=0x44, pop_valid=1, count=2; next pop -> 0x55.
REQ-036 Empty stack, push 0x66 with pop -> pop_data=0x66, pop_valid=1, count=0, empty=1.
REQ-037 With count=5, drive rst_n low between clk edges -> count=0, pop_valid=0 immediately; subsequent pop sets underflow.
